// File: rtl/ex_bj_redirect_unit_pkg.sv
// Shared types and op encoding for the branch/jump execute unit.
package ZionDataType;

    localparam int BJ_OP_W = 6;

    // one-hot op bit positions
    localparam int BJ_LT   = 0;
    localparam int BJ_GE   = 1;
    localparam int BJ_EQ   = 2;
    localparam int BJ_NE   = 3;
    localparam int BJ_JALR = 4;
    localparam int BJ_JAL  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } BjState_e;

endpackage

// File: rtl/ex_bj_resolve.sv
// Combinational resolve: compare, target, link and target alignment check.
module ex_bj_resolve
    import ZionDataType::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4,
    parameter int OP_W   = BJ_OP_W
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] s1,
    input  logic [XLEN-1:0] s2,
    input  logic            s1_sign,
    input  logic            s2_sign,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            compressed,
    output logic            taken,
    output logic            is_jump,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link,
    output logic            misaligned
);

    localparam bit COMPRESSED_OK = (IALIGN == 2);

    logic            lt;
    logic            eq;
    logic [XLEN-1:0] jalr_sum;

    // the sign bits extend each operand so one compare covers signed and unsigned
    assign lt = $signed({s1_sign, s1}) < $signed({s2_sign, s2});
    assign eq = (s1 == s2);

    assign is_jump = op[BJ_JAL] | op[BJ_JALR];
    assign taken   = (op[BJ_LT] & lt) | (op[BJ_GE] & ~lt) |
                     (op[BJ_EQ] & eq) | (op[BJ_NE] & ~eq) | is_jump;

    assign jalr_sum = s1 + imm;
    assign target   = op[BJ_JALR] ? {jalr_sum[XLEN-1:1], 1'b0} : (pc + imm);
    assign link     = pc + ((COMPRESSED_OK && compressed) ? XLEN'(2) : XLEN'(4));

    generate
        if (IALIGN == 2) begin : g_align2
            assign misaligned = target[0];
        end else begin : g_align4
            assign misaligned = |target[1:0];
        end
    endgenerate

endmodule

// File: rtl/ex_bj_redirect_unit.sv
// Branch/jump execute unit with a held, handshaked fetch redirect and epoch-based squash.
// Optional ZION_BJ_PREDICT_EN: redirect only on mispredict and pulse oBtbUpd per resolved op.
//
// state | meaning
// IDLE  | no redirect outstanding, ready for an op
// PEND  | redirect held on oRedirPc until fetch takes it
module ex_bj_redirect_unit
    import ZionDataType::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4,
    parameter int OP_W   = BJ_OP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iValid,
    output logic            oReady,
    input  logic [OP_W-1:0] iOp,
    input  logic            iEpoch,
    input  logic [XLEN-1:0] iS1,
    input  logic [XLEN-1:0] iS2,
    input  logic            iS1Sign,
    input  logic            iS2Sign,
    input  logic [XLEN-1:0] iPc,
    input  logic [XLEN-1:0] iImm,
    input  logic            iCompressed,
    input  logic            iFlush,
`ifdef ZION_BJ_PREDICT_EN
    input  logic            iPredTaken,
    input  logic [XLEN-1:0] iPredPc,
    output logic            oBtbUpd,
`endif
    output logic            oRedirValid,
    input  logic            iRedirReady,
    output logic [XLEN-1:0] oRedirPc,
    output logic            oResValid,
    output logic [XLEN-1:0] oResData,
    output logic            oExcValid,
    output logic [XLEN-1:0] oExcTval,
    output logic            oEpoch
);

    typedef struct packed {
        logic [XLEN-1:0] Pc;
        logic            Valid;
    } Redirect_s;

    BjState_e        state, state_next;
    logic            epoch_q, epoch_next;
    logic [XLEN-1:0] redir_pc_q, redir_pc_next;
    logic            res_valid_q, res_valid_next;
    logic [XLEN-1:0] res_data_q, res_data_next;
    logic            exc_valid_q, exc_valid_next;
    logic [XLEN-1:0] exc_tval_q, exc_tval_next;

    logic            taken;
    logic            is_jump;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            misaligned;
    logic            accept;
    logic            act;
    logic            take_exc;
    Redirect_s       redir_req;

    ex_bj_resolve #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN),
        .OP_W   (OP_W)
    ) u_resolve (
        .op         (iOp),
        .s1         (iS1),
        .s2         (iS2),
        .s1_sign    (iS1Sign),
        .s2_sign    (iS2Sign),
        .pc         (iPc),
        .imm        (iImm),
        .compressed (iCompressed),
        .taken      (taken),
        .is_jump    (is_jump),
        .target     (target),
        .link       (link),
        .misaligned (misaligned)
    );

    assign oReady   = (state == IDLE) | iRedirReady;
    assign accept   = iValid & oReady & ~iFlush;
    // stale-epoch and all-zero ops are consumed without effect
    assign act      = accept & (iEpoch == epoch_q) & (|iOp);
    assign take_exc = act & taken & misaligned;

`ifdef ZION_BJ_PREDICT_EN
    logic mispredict;
    logic btb_upd_q;

    assign mispredict = (taken != iPredTaken) | (taken & (target != iPredPc));

    always_comb begin
        redir_req.Valid = act & ~take_exc & mispredict;
        redir_req.Pc    = taken ? target : link;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) btb_upd_q <= 1'b0;
        else     btb_upd_q <= act;
    end

    assign oBtbUpd = btb_upd_q;
`else
    always_comb begin
        redir_req.Valid = act & taken & ~misaligned;
        redir_req.Pc    = target;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        epoch_next     = epoch_q;
        redir_pc_next  = redir_pc_q;
        res_valid_next = 1'b0;
        res_data_next  = res_data_q;
        exc_valid_next = 1'b0;
        exc_tval_next  = exc_tval_q;
        if (iFlush) begin
            state_next = IDLE;
            epoch_next = ~epoch_q;
        end else begin
            if ((state == PEND) && iRedirReady) begin
                state_next = IDLE;
            end
            // a new redirect may replace one draining this same cycle
            if (redir_req.Valid) begin
                state_next    = PEND;
                redir_pc_next = redir_req.Pc;
                epoch_next    = ~epoch_q;
            end
            if (act & is_jump & ~misaligned) begin
                res_valid_next = 1'b1;
                res_data_next  = link;
            end
            if (take_exc) begin
                exc_valid_next = 1'b1;
                exc_tval_next  = target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epoch_q     <= 1'b0;
            redir_pc_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            exc_valid_q <= 1'b0;
            exc_tval_q  <= '0;
        end else begin
            epoch_q     <= epoch_next;
            redir_pc_q  <= redir_pc_next;
            res_valid_q <= res_valid_next;
            res_data_q  <= res_data_next;
            exc_valid_q <= exc_valid_next;
            exc_tval_q  <= exc_tval_next;
        end
    end

    assign oRedirValid = (state == PEND);
    assign oRedirPc    = redir_pc_q;
    assign oResValid   = res_valid_q;
    assign oResData    = res_data_q;
    assign oExcValid   = exc_valid_q;
    assign oExcTval    = exc_tval_q;
    assign oEpoch      = epoch_q;

endmodule

// File: tb/tb_ex_bj_redirect_unit.sv
// Bench for ex_bj_redirect_unit: one instance per IALIGN (4 and 2), directed plus randomized checks.
module tb_ex_bj_redirect_unit;

    localparam logic [5:0] OP_LT = 6'b000001, OP_GE = 6'b000010, OP_EQ = 6'b000100,
                           OP_NE = 6'b001000, OP_JALR = 6'b010000, OP_JAL = 6'b100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  in_op;
    logic        ep_in [2];
    logic [31:0] s1, s2, pc, imm;
    logic        s1sg, s2sg, comp, flush, rr;

    logic        ready [2];
    logic        rv    [2];
    logic [31:0] rpc   [2];
    logic        resv  [2];
    logic [31:0] resd  [2];
    logic        excv  [2];
    logic [31:0] tval  [2];
    logic        epo   [2];

    // reference model state, index 0 = IALIGN 4, index 1 = IALIGN 2
    bit        m_pend [2];
    bit [31:0] m_pc   [2];
    bit        m_ep   [2];
    bit        e_resv [2];
    bit [31:0] e_resd [2];
    bit        e_excv [2];
    bit [31:0] e_tval [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_bj_redirect_unit #(.XLEN(32), .IALIGN(4)) dut (
        .clk(clk), .rst(rst), .iValid(in_valid), .oReady(ready[0]), .iOp(in_op),
        .iEpoch(ep_in[0]), .iS1(s1), .iS2(s2), .iS1Sign(s1sg), .iS2Sign(s2sg),
        .iPc(pc), .iImm(imm), .iCompressed(comp), .iFlush(flush),
        .oRedirValid(rv[0]), .iRedirReady(rr), .oRedirPc(rpc[0]),
        .oResValid(resv[0]), .oResData(resd[0]), .oExcValid(excv[0]),
        .oExcTval(tval[0]), .oEpoch(epo[0])
    );

    ex_bj_redirect_unit #(.XLEN(32), .IALIGN(2)) dut2 (
        .clk(clk), .rst(rst), .iValid(in_valid), .oReady(ready[1]), .iOp(in_op),
        .iEpoch(ep_in[1]), .iS1(s1), .iS2(s2), .iS1Sign(s1sg), .iS2Sign(s2sg),
        .iPc(pc), .iImm(imm), .iCompressed(comp), .iFlush(flush),
        .oRedirValid(rv[1]), .iRedirReady(rr), .oRedirPc(rpc[1]),
        .oResValid(resv[1]), .oResData(resd[1]), .oExcValid(excv[1]),
        .oExcTval(tval[1]), .oEpoch(epo[1])
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_pc[k] = 0; m_ep[k] = 0;
            e_resv[k] = 0; e_resd[k] = 0; e_excv[k] = 0; e_tval[k] = 0;
        end
    endtask

    // Next-cycle expectations computed from the architectural rules with plain arithmetic.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int ia;
            bit rdy, tk, jmp;
            longint a, b;
            longint unsigned tgt, lnk;
            ia  = (k == 1) ? 2 : 4;
            rdy = !m_pend[k] || rr;
            e_resv[k] = 0;
            e_excv[k] = 0;
            if (flush) begin
                m_pend[k] = 0;
                m_ep[k]   = !m_ep[k];
            end else begin
                if (m_pend[k] && rr) m_pend[k] = 0;
                if (in_valid && rdy && ep_in[k] == m_ep[k] && in_op != 0) begin
                    a = longint'(s1); if (s1sg) a = a - 64'sh1_0000_0000;
                    b = longint'(s2); if (s2sg) b = b - 64'sh1_0000_0000;
                    jmp = (in_op == OP_JAL) || (in_op == OP_JALR);
                    case (in_op)
                        OP_LT:   tk = (a < b);
                        OP_GE:   tk = (a >= b);
                        OP_EQ:   tk = (s1 == s2);
                        OP_NE:   tk = (s1 != s2);
                        default: tk = 1;
                    endcase
                    if (in_op == OP_JALR)
                        tgt = ((longint'(s1) + longint'(imm)) % 64'h1_0000_0000) / 2 * 2;
                    else
                        tgt = (longint'(pc) + longint'(imm)) % 64'h1_0000_0000;
                    lnk = (longint'(pc) + ((ia == 2 && comp) ? 2 : 4)) % 64'h1_0000_0000;
                    if (tk) begin
                        if (tgt % ia != 0) begin
                            e_excv[k] = 1; e_tval[k] = tgt[31:0];
                        end else begin
                            m_pend[k] = 1; m_pc[k] = tgt[31:0]; m_ep[k] = !m_ep[k];
                            if (jmp) begin e_resv[k] = 1; e_resd[k] = lnk[31:0]; end
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] p, input logic [31:0] i);
        in_valid = 1; in_op = op; s1 = a; s2 = b; pc = p; imm = i;
        s1sg = 0; s2sg = 0; comp = 0; flush = 0;
        ep_in[0] = m_ep[0]; ep_in[1] = m_ep[1];
    endtask

    task automatic drive_idle();
        in_valid = 0; in_op = 0; flush = 0; comp = 0; s1sg = 0; s2sg = 0;
        ep_in[0] = m_ep[0]; ep_in[1] = m_ep[1];
    endtask

    task automatic test_reset();
        drive_idle(); rr = 0; s1 = 0; s2 = 0; pc = 0; imm = 0;
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if ({rv[k], resv[k], excv[k], epo[k]} !== 4'b0000 || rpc[k] !== 0 ||
                resd[k] !== 0 || tval[k] !== 0 || ready[k] !== 1'b1) begin
                fails++;
                $display("FAIL reset[%0d]: rv=%b resv=%b excv=%b ep=%b rpc=%h resd=%h tval=%h rdy=%b, want zeros and rdy=1",
                         k, rv[k], resv[k], excv[k], epo[k], rpc[k], resd[k], tval[k], ready[k]);
            end
        end
        rst = 0;
        tick();
    endtask

    task automatic test_blt();
        bit ep0 [2];
        drive_op(OP_LT, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
        s1sg = 1; rr = 1;
        ep0[0] = m_ep[0]; ep0[1] = m_ep[1];
        tick();
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (rv[k] !== 1'b1 || rpc[k] !== 32'h120 || epo[k] !== !ep0[k]) begin
                fails++;
                $display("FAIL blt_signed[%0d]: rv=%b pc=%h ep=%b, want 1 120 %b", k, rv[k], rpc[k], epo[k], !ep0[k]);
            end
        end
        drive_op(OP_LT, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
        tick();
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (rv[k] !== 1'b0) begin
                fails++;
                $display("FAIL blt_unsigned[%0d]: rv=%b want 0", k, rv[k]);
            end
        end
    endtask

    task automatic test_jalr_align();
        drive_op(OP_JALR, 32'h1003, 32'h0, 32'h200, 32'h0);
        rr = 1;
        tick();
        drive_idle();
        tests++;
        if (rv[1] !== 1'b1 || rpc[1] !== 32'h1002 || resv[1] !== 1'b1 || resd[1] !== 32'h204) begin
            fails++;
            $display("FAIL jalr_ialign2: rv=%b pc=%h resv=%b resd=%h, want 1 1002 1 204", rv[1], rpc[1], resv[1], resd[1]);
        end
        tests++;
        if (excv[0] !== 1'b1 || tval[0] !== 32'h1002 || rv[0] !== 1'b0 || resv[0] !== 1'b0) begin
            fails++;
            $display("FAIL jalr_ialign4_exc: excv=%b tval=%h rv=%b resv=%b, want 1 1002 0 0", excv[0], tval[0], rv[0], resv[0]);
        end
        tick();
        tests++;
        if (excv[0] !== 1'b0 || resv[1] !== 1'b0) begin
            fails++;
            $display("FAIL pulse_width: excv=%b resv=%b, want 0 0", excv[0], resv[1]);
        end
    endtask

    task automatic test_backpressure();
        drive_op(OP_EQ, 32'h5, 32'h5, 32'h300, 32'h40);
        rr = 0;
        tick();
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (rv[k] !== 1'b1 || rpc[k] !== 32'h340 || ready[k] !== 1'b0) begin
                    fails++;
                    $display("FAIL hold[%0d] cyc %0d: rv=%b pc=%h rdy=%b, want 1 340 0", k, c, rv[k], rpc[k], ready[k]);
                end
            end
            tick();
        end
        rr = 1;
        drive_op(OP_NE, 32'h1, 32'h2, 32'h400, 32'h10);
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (ready[k] !== 1'b1) begin
                fails++;
                $display("FAIL drain_ready[%0d]: rdy=%b want 1", k, ready[k]);
            end
        end
        tick();
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (rv[k] !== 1'b1 || rpc[k] !== 32'h410) begin
                fails++;
                $display("FAIL back_to_back[%0d]: rv=%b pc=%h, want 1 410", k, rv[k], rpc[k]);
            end
        end
        tick();
    endtask

    task automatic test_epoch();
        bit ep_now [2];
        rr = 1;
        drive_op(OP_EQ, 32'h7, 32'h7, 32'h500, 32'h80);
        tick();
        drive_op(OP_JAL, 32'h0, 32'h0, 32'h500, 32'h100);
        ep_in[0] = !m_ep[0]; ep_in[1] = !m_ep[1];
        ep_now[0] = m_ep[0]; ep_now[1] = m_ep[1];
        tick();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (resv[k] !== 1'b0 || rv[k] !== 1'b0 || epo[k] !== ep_now[k]) begin
                fails++;
                $display("FAIL stale_op[%0d]: resv=%b rv=%b ep=%b, want 0 0 %b", k, resv[k], rv[k], epo[k], ep_now[k]);
            end
        end
        ep_in[0] = m_ep[0]; ep_in[1] = m_ep[1];
        tick();
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (resv[k] !== 1'b1 || resd[k] !== 32'h504 || rv[k] !== 1'b1 || rpc[k] !== 32'h600) begin
                fails++;
                $display("FAIL current_op[%0d]: resv=%b resd=%h rv=%b pc=%h, want 1 504 1 600", k, resv[k], resd[k], rv[k], rpc[k]);
            end
        end
        tick();
    endtask

    task automatic test_flush();
        bit ep0 [2];
        rr = 0;
        drive_op(OP_EQ, 32'h9, 32'h9, 32'h700, 32'h40);
        tick();
        drive_op(OP_JAL, 32'h0, 32'h0, 32'h800, 32'h20);
        flush = 1; rr = 1;
        ep0[0] = m_ep[0]; ep0[1] = m_ep[1];
        tick();
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (rv[k] !== 1'b0 || resv[k] !== 1'b0 || epo[k] !== !ep0[k]) begin
                fails++;
                $display("FAIL flush_pend[%0d]: rv=%b resv=%b ep=%b, want 0 0 %b", k, rv[k], resv[k], epo[k], !ep0[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (rv[k] !== 1'b0 || resv[k] !== 1'b0) begin
                fails++;
                $display("FAIL flush_no_accept[%0d]: rv=%b resv=%b, want 0 0", k, rv[k], resv[k]);
            end
        end
    endtask

    task automatic test_wrap();
        rr = 1;
        drive_op(OP_JAL, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8);
        tick();
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (rv[k] !== 1'b1 || rpc[k] !== 32'h4 || resv[k] !== 1'b1 || resd[k] !== 32'h0) begin
                fails++;
                $display("FAIL jal_wrap[%0d]: rv=%b pc=%h resv=%b resd=%h, want 1 4 1 0", k, rv[k], rpc[k], resv[k], resd[k]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_pend();
        rr = 0;
        drive_op(OP_NE, 32'h1, 32'h3, 32'h900, 32'h10);
        tick();
        drive_idle();
        #2;
        rst = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (rv[k] !== 1'b0 || epo[k] !== 1'b0 || ready[k] !== 1'b1 || rpc[k] !== 0) begin
                fails++;
                $display("FAIL async_reset[%0d]: rv=%b ep=%b rdy=%b pc=%h, want 0 0 1 0", k, rv[k], epo[k], ready[k], rpc[k]);
            end
        end
        rst = 0;
        model_reset();
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            int r;
            r = $urandom_range(0, 6);
            in_valid = ($urandom_range(0, 3) != 0);
            in_op    = (r == 6) ? 6'b0 : 6'(1 << r);
            s1       = ($urandom_range(0, 3) == 0) ? 32'(n) : $urandom;
            s2       = ($urandom_range(0, 3) == 0) ? s1 : $urandom;
            s1sg     = 1'($urandom_range(0, 1));
            s2sg     = 1'($urandom_range(0, 1));
            pc       = $urandom & ~32'h1;
            imm      = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3);
            comp     = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 11) == 0);
            rr       = 1'($urandom_range(0, 1));
            for (int k = 0; k < 2; k++)
                ep_in[k] = ($urandom_range(0, 3) == 0) ? !m_ep[k] : m_ep[k];
            #1;
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (ready[k] !== (!m_pend[k] || rr)) begin
                    fails++;
                    $display("FAIL rnd_ready[%0d] n=%0d: got %b want %b", k, n, ready[k], !m_pend[k] || rr);
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (rv[k] !== m_pend[k] || (m_pend[k] && rpc[k] !== m_pc[k]) || epo[k] !== m_ep[k]) begin
                    fails++;
                    $display("FAIL rnd_redir[%0d] n=%0d: rv=%b pc=%h ep=%b, want %b %h %b",
                             k, n, rv[k], rpc[k], epo[k], m_pend[k], m_pc[k], m_ep[k]);
                end
                tests++;
                if (resv[k] !== e_resv[k] || (e_resv[k] && resd[k] !== e_resd[k])) begin
                    fails++;
                    $display("FAIL rnd_link[%0d] n=%0d: resv=%b resd=%h, want %b %h", k, n, resv[k], resd[k], e_resv[k], e_resd[k]);
                end
                tests++;
                if (excv[k] !== e_excv[k] || (e_excv[k] && tval[k] !== e_tval[k])) begin
                    fails++;
                    $display("FAIL rnd_exc[%0d] n=%0d: excv=%b tval=%h, want %b %h", k, n, excv[k], tval[k], e_excv[k], e_tval[k]);
                end
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_blt();
        test_jalr_align();
        test_backpressure();
        test_epoch();
        test_flush();
        test_wrap();
        test_reset_mid_pend();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
